qp_mem_port_arbiter: RTL
========================

Name: qp_mem_port_arbiter

Overview:
- Shares the single read/write port (port 0) of the query-patch SRAM between two requesters: the Wishbone slave controller (debug/host access) and the ANN search engine (query fetch / writeback).
- Arbitrates every cycle, drives the active-low SRAM controls from a registered stage, and routes the one-cycle-latency read data back to the owning requester with a valid pulse.
- Sits between wbsCtrl / engine and the qp SRAM macro in the top level.

Parameters:
- ADDR_W, 9, SRAM word address width; $clog2(ROW_SIZE*COL_SIZE) with ROW_SIZE=24, COL_SIZE=17.
- DATA_W, 55, SRAM word width; PATCH_SIZE*DATA_WIDTH.
- CNT_W, 16, width of the performance counters; used only with the optional feature.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- wbs_mode  in  1  1 = Wishbone-exclusive access, 0 = shared round-robin.
- wbs_req / eng_req  in  1  request valid.
- wbs_we / eng_we  in  1  1 = write, 0 = read.
- wbs_addr / eng_addr  in  ADDR_W  word address.
- wbs_wdata / eng_wdata  in  DATA_W  write data.
- wbs_gnt / eng_gnt  out  1  combinational accept in the same cycle as the request.
- wbs_rvalid / eng_rvalid  out  1  one-cycle pulse with read data.
- wbs_rdata / eng_rdata  out  DATA_W  read data; meaningful only while rvalid is high.
- mem_csb0  out  1  SRAM chip select, active low.
- mem_web0  out  1  SRAM write enable, active low.
- mem_addr0  out  ADDR_W  SRAM address.
- mem_wdata0  out  DATA_W  SRAM write data.
- mem_rdata0  in  DATA_W  SRAM read data; valid the cycle after the access cycle.
- wbs_gnt_cnt / eng_gnt_cnt  out  CNT_W  grant counters (optional feature).

Behaviour:
- Reset values: mem_csb0=1, mem_web0=1, mem_addr0=0, mem_wdata0=0. All gnt and rvalid outputs 0. rdata outputs 0. Round-robin pointer resets to "engine next". Tag pipeline cleared.
- Handshake:
  - A request is transferred on any rising edge where req && gnt.
  - The requester holds req, we, addr and wdata stable until granted.
  - gnt is never asserted without req.
- Grant policy:
  - wbs_mode=1: wbs_gnt=wbs_req; eng_gnt=0.
  - wbs_mode=0, single requester: that requester is granted.
  - wbs_mode=0, both requesting: grant the side the pointer selects; the pointer then flips to the other side.
  - The pointer updates only on a contended grant.
- Access stage:
  - A request granted at edge t is registered.
  - During cycle t..t+1: mem_csb0=0, mem_web0=~we, addr and wdata driven.
  - With no grant, mem_csb0=1 and mem_web0=1; addr and wdata hold their previous values.
- Read return:
  - Tag pipeline {valid, owner} advances one stage per cycle.
  - mem_rdata0 is captured into the owner's rdata register; rvalid pulses in cycle t+2 (latency 2 clocks from grant edge to rvalid).
  - Writes produce no rvalid.
- Throughput: one access per cycle, back-to-back. A read followed by a write is legal with no bubble.
- wbs_mode change: takes effect for grants in the same cycle. In-flight reads still return to their original owner.
- Reset mid-operation: in-flight reads are dropped (no rvalid) and the SRAM returns to idle on the next edge.
- Address range: no range checking. Out-of-range addresses are passed through unchanged.

Optional Feature:
- QP_ARB_PERF_CNT_EN defined:
  - wbs_gnt_cnt and eng_gnt_cnt increment on each grant to their side.
  - Both are saturating at all-ones and cleared by wb_rst_i.
- Undefined: both counter outputs are tied to 0 and no counter flops are generated.

Decomposition:
- Shared package qp_arb_pkg:
  - owner_e enum (OWNER_WBS=0, OWNER_ENG=1).
  - tag_t struct {logic valid; owner_e owner}.
  - Localparams SRAM_RD_LAT=1 and ARB_LAT=2.
- Sub-module rr_arb2: a 2-way round-robin arbiter with a priority pointer, a mask input driven by wbs_mode, and a gnt vector output. The data mux and tag pipeline stay in the top module.

Test Plan:
- Reset, then wbs_mode=1, wbs read addr 1 with mem_rdata0=55'h00_1010_DEAD_BEEF at t+1 -> wbs_rvalid pulses at t+2 with wbs_rdata=55'h00_1010_DEAD_BEEF; eng_rvalid stays 0.
- wbs_mode=1, eng_req held for 10 cycles with no wbs traffic -> eng_gnt stays 0 and mem_csb0 stays 1 throughout.
- wbs_mode=0, both requesting reads continuously (wbs addr 3, eng addr 5) -> grants alternate eng, wbs, eng, …; mem_addr0 alternates 5, 3; each rvalid reaches the correct owner.
- Engine write addr 2 data 55'h0B_CDEF_0123_4567, followed next cycle by a wbs read addr 2 -> cycle 1 shows mem_web0=0 with that data; cycle 2 shows mem_web0=1, addr 2; wbs_rvalid appears 2 cycles after its grant.
- Engine read granted, then wb_rst_i asserted for one cycle before the return -> no eng_rvalid, and all outputs are at their reset values on the following cycle.
- With QP_ARB_PERF_CNT_EN, 70000 wbs grants -> wbs_gnt_cnt=16'hFFFF (saturated) and eng_gnt_cnt=0.

Source files
------------

// File: rtl/qp_arb_pkg.sv
// Shared types and latency constants for the query-patch SRAM port arbiter.
package qp_arb_pkg;

    typedef enum logic {
        OWNER_WBS = 1'b0,
        OWNER_ENG = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } tag_t;

    localparam int SRAM_RD_LAT = 1;
    localparam int ARB_LAT     = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; index 0 = Wishbone, 1 = engine. mask blocks the engine.
module rr_arb2
    import qp_arb_pkg::*;
(
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic [1:0] req,
    input  logic       mask,
    output logic [1:0] gnt
);

    owner_e     ptr_reg;
    owner_e     ptr_next;
    logic [1:0] req_m;

    always_comb begin
        req_m    = {req[OWNER_ENG] & ~mask, req[OWNER_WBS]};
        gnt      = req_m;
        ptr_next = ptr_reg;
        // The pointer only moves when both sides actually compete.
        if (req_m == 2'b11) begin
            gnt           = 2'b00;
            gnt[ptr_reg]  = 1'b1;
            ptr_next      = (ptr_reg == OWNER_ENG) ? OWNER_WBS : OWNER_ENG;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ptr_reg <= OWNER_ENG;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/qp_mem_port_arbiter.sv
// Shares qp SRAM port 0 between the Wishbone controller and the search engine.
// Optional grant counters are built when QP_ARB_PERF_CNT_EN is defined.
module qp_mem_port_arbiter
    import qp_arb_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 55,
    parameter int CNT_W  = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_mode,
    input  logic              wbs_req,
    input  logic              wbs_we,
    input  logic [ADDR_W-1:0] wbs_addr,
    input  logic [DATA_W-1:0] wbs_wdata,
    output logic              wbs_gnt,
    output logic              wbs_rvalid,
    output logic [DATA_W-1:0] wbs_rdata,
    input  logic              eng_req,
    input  logic              eng_we,
    input  logic [ADDR_W-1:0] eng_addr,
    input  logic [DATA_W-1:0] eng_wdata,
    output logic              eng_gnt,
    output logic              eng_rvalid,
    output logic [DATA_W-1:0] eng_rdata,
    output logic              mem_csb0,
    output logic              mem_web0,
    output logic [ADDR_W-1:0] mem_addr0,
    output logic [DATA_W-1:0] mem_wdata0,
    input  logic [DATA_W-1:0] mem_rdata0,
    output logic [CNT_W-1:0]  wbs_gnt_cnt,
    output logic [CNT_W-1:0]  eng_gnt_cnt
);

    logic [1:0]              req_vec;
    logic [1:0]              gnt_vec;
    logic                    granted;
    logic                    sel_eng;
    logic                    sel_we;
    logic [ADDR_W-1:0]       sel_addr;
    logic [DATA_W-1:0]       sel_wdata;
    logic                    csb_reg;
    logic                    web_reg;
    logic [ADDR_W-1:0]       addr_reg;
    logic [DATA_W-1:0]       wdata_reg;
    tag_t                    tag_reg [ARB_LAT];
    logic [1:0]              rvalid_vec;
    logic [1:0][DATA_W-1:0]  rdata_vec;

    // Grants are suppressed while in reset so the SRAM goes idle cleanly.
    assign req_vec[OWNER_WBS] = wbs_req & ~wb_rst_i;
    assign req_vec[OWNER_ENG] = eng_req & ~wb_rst_i;

    rr_arb2 u_arb (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .req      (req_vec),
        .mask     (wbs_mode),
        .gnt      (gnt_vec)
    );

    assign wbs_gnt   = gnt_vec[OWNER_WBS];
    assign eng_gnt   = gnt_vec[OWNER_ENG];
    assign granted   = |gnt_vec;
    assign sel_eng   = gnt_vec[OWNER_ENG];
    assign sel_we    = sel_eng ? eng_we    : wbs_we;
    assign sel_addr  = sel_eng ? eng_addr  : wbs_addr;
    assign sel_wdata = sel_eng ? eng_wdata : wbs_wdata;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            csb_reg   <= 1'b1;
            web_reg   <= 1'b1;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            csb_reg <= ~granted;
            web_reg <= ~(granted & sel_we);
            if (granted) begin
                addr_reg  <= sel_addr;
                wdata_reg <= sel_wdata;
            end
        end
    end

    assign mem_csb0   = csb_reg;
    assign mem_web0   = web_reg;
    assign mem_addr0  = addr_reg;
    assign mem_wdata0 = wdata_reg;

    // Stage 0 lines up with the access cycle, the last stage with valid SRAM data.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < ARB_LAT; i++) begin
                tag_reg[i] <= '{valid: 1'b0, owner: OWNER_WBS};
            end
        end else begin
            tag_reg[0] <= '{valid: granted & ~sel_we, owner: owner_e'(sel_eng)};
            for (int i = 1; i < ARB_LAT; i++) begin
                tag_reg[i] <= tag_reg[i-1];
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_ret
        logic              hit;
        logic              rvalid_reg;
        logic [DATA_W-1:0] rdata_reg;

        assign hit = tag_reg[ARB_LAT-1].valid &&
                     (tag_reg[ARB_LAT-1].owner == ((gi == 1) ? OWNER_ENG : OWNER_WBS));

        always_ff @(posedge wb_clk_i) begin
            if (wb_rst_i) begin
                rvalid_reg <= 1'b0;
                rdata_reg  <= '0;
            end else begin
                rvalid_reg <= hit;
                if (hit) begin
                    rdata_reg <= mem_rdata0;
                end
            end
        end

        assign rvalid_vec[gi] = rvalid_reg;
        assign rdata_vec[gi]  = rdata_reg;
    end

    assign wbs_rvalid = rvalid_vec[OWNER_WBS];
    assign eng_rvalid = rvalid_vec[OWNER_ENG];
    assign wbs_rdata  = rdata_vec[OWNER_WBS];
    assign eng_rdata  = rdata_vec[OWNER_ENG];

`ifdef QP_ARB_PERF_CNT_EN
    logic [1:0][CNT_W-1:0] cnt_vec;

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_reg;

        always_ff @(posedge wb_clk_i) begin
            if (wb_rst_i) begin
                cnt_reg <= '0;
            end else if (gnt_vec[gi] && !(&cnt_reg)) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end

        assign cnt_vec[gi] = cnt_reg;
    end

    assign wbs_gnt_cnt = cnt_vec[OWNER_WBS];
    assign eng_gnt_cnt = cnt_vec[OWNER_ENG];
`else
    assign wbs_gnt_cnt = '0;
    assign eng_gnt_cnt = '0;
`endif

endmodule
